// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller connects through master, the datapath side through slave.
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       op_code;
   logic [2:0]       funct_3;
   logic             funct_7;
   logic             zero;
   logic             mem_ready;

   logic             pc_write;
   logic             adr_src;
   logic             mem_write;
   logic             ir_write;
   logic [1:0]       result_src;
   logic [2:0]       alu_control;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       imm_src;
   logic             reg_write;
   logic             illegal;
   logic [3:0]       state_dbg;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  op_code, funct_3, funct_7, zero, mem_ready,
      output pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
             alu_src_a, alu_src_b, imm_src, reg_write, illegal, state_dbg,
             instr_count
   );

   modport slave (
      output op_code, funct_3, funct_7, zero, mem_ready,
      input  pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
             alu_src_a, alu_src_b, imm_src, reg_write, illegal, state_dbg,
             instr_count
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: main/ALU decode sequenced over shared memory
// and ALU, with memory wait, optional BNE, illegal-opcode trap and retire count.
module multicycle_controller #(
   parameter int MEM_WAIT_EN = 1,
   parameter int BNE_EN      = 1,
   parameter int CNT_W       = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   multicycle_controller_if.master        bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // Moore part of the control word; fetch/mem_wr/branch mark the states
   // whose enables are qualified by mem_ready or zero.
   typedef struct packed {
      logic       adr_src;
      logic [1:0] result_src;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       pc_write;
      logic       fetch;
      logic       mem_wr;
      logic       branch;
   } ctrl_t;

   function automatic ctrl_t decode_state(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:    begin c.src_b = 2'b10; c.result_src = 2'b10; c.fetch = 1'b1; end
         DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
         MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
         MEMREAD:  c.adr_src = 1'b1;
         MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
         MEMWRITE: begin c.adr_src = 1'b1; c.mem_wr = 1'b1; end
         EXECR:    begin c.src_a = 2'b10; c.alu_op = 2'b10; end
         EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
         ALUWB:    c.reg_write = 1'b1;
         BRANCH:   begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
         JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_e           state_q, state_d;
   ctrl_t            ctrl_q;
   logic             illegal_q;
   logic [CNT_W-1:0] cnt_q;
   logic             retire;
   logic             mem_rdy;
   logic             alu_f3_ok;
   logic             br_f3_ok;

   assign mem_rdy   = (MEM_WAIT_EN == 0) || bus.mem_ready;
   assign alu_f3_ok = bus.funct_3 inside {3'b000, 3'b010, 3'b110, 3'b111};
   assign br_f3_ok  = (bus.funct_3 == 3'b000) ||
                      ((BNE_EN != 0) && (bus.funct_3 == 3'b001));

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         FETCH:    if (mem_rdy) state_d = DECODE;
         DECODE: begin
            case (bus.op_code)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = alu_f3_ok ? EXECR  : TRAP;
               OP_I:         state_d = alu_f3_ok ? EXECI  : TRAP;
               OP_BR:        state_d = br_f3_ok  ? BRANCH : TRAP;
               OP_JAL:       state_d = JAL;
               default:      state_d = TRAP;
            endcase
         end
         MEMADR:   state_d = (bus.op_code == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  if (mem_rdy) state_d = MEMWB;
         MEMWRITE: if (mem_rdy) begin state_d = FETCH; retire = 1'b1; end
         MEMWB, ALUWB, BRANCH: begin
            state_d = FETCH;
            retire  = 1'b1;
         end
         EXECR, EXECI, JAL: state_d = ALUWB;
         default:  state_d = TRAP;
      endcase
   end

   // Control word is registered from the next state so it lines up with state_q.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= FETCH;
         ctrl_q    <= decode_state(FETCH);
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode_state(state_d);
         if (state_d == TRAP) illegal_q <= 1'b1;
         if (retire) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      bus.alu_control = 3'b000;
      case (ctrl_q.alu_op)
         2'b01: bus.alu_control = 3'b001;
         2'b10: begin
            case (bus.funct_3)
               3'b000:  bus.alu_control = (bus.op_code[5] && bus.funct_7) ? 3'b001 : 3'b000;
               3'b010:  bus.alu_control = 3'b101;
               3'b110:  bus.alu_control = 3'b011;
               3'b111:  bus.alu_control = 3'b010;
               default: bus.alu_control = 3'b000;
            endcase
         end
         default: bus.alu_control = 3'b000;
      endcase
   end

   always_comb begin
      case (bus.op_code)
         OP_SW:   bus.imm_src = 2'b01;
         OP_BR:   bus.imm_src = 2'b10;
         OP_JAL:  bus.imm_src = 2'b11;
         default: bus.imm_src = 2'b00;
      endcase
   end

   // funct_3[0] separates BNE from BEQ; only those two reach BRANCH.
   assign bus.pc_write  = reset && (ctrl_q.pc_write || (ctrl_q.fetch && mem_rdy) ||
                                    (ctrl_q.branch && (bus.zero ^ bus.funct_3[0])));
   assign bus.ir_write  = reset && ctrl_q.fetch && mem_rdy;
   assign bus.mem_write = reset && ctrl_q.mem_wr && mem_rdy;
   assign bus.reg_write = reset && ctrl_q.reg_write;

   assign bus.adr_src     = ctrl_q.adr_src;
   assign bus.result_src  = ctrl_q.result_src;
   assign bus.alu_src_a   = ctrl_q.src_a;
   assign bus.alu_src_b   = ctrl_q.src_b;
   assign bus.illegal     = illegal_q;
   assign bus.state_dbg   = state_q;
   assign bus.instr_count = cnt_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I core; successor to the single-cycle controller.
- Same decode (main opcode decode + ALU decode), but sequenced through an FSM so datapath resources (one memory, one ALU) are reused across cycles.
- Adds a memory wait handshake, optional BNE, illegal-opcode trap, and a retired-instruction counter.
- Sits between the instruction register and the multicycle datapath.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour mem_ready; 0 = mem_ready is ignored and treated as 1.
- BNE_EN, 1: 1 = funct_3 001 on a branch opcode is a legal BNE; 0 = it is illegal.
- CNT_W, 32: width of instr_count.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- op_code  in  7  instr[6:0] from the instruction register
- funct_3  in  3  instr[14:12]
- funct_7  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0 = PC, 1 = result
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register and old-PC enable
- result_src  out  2  00 alu_out, 01 data, 10 alu_result
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- imm_src  out  2  00 I, 01 S, 10 B, 11 J; combinational from op_code, valid in every state
- reg_write  out  1  register file write enable
- illegal  out  1  sticky illegal-instruction flag
- state_dbg  out  4  current state encoding
- instr_count  out  CNT_W  retired instruction counter

Behaviour:
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11
- Reset (reset = 0 at a clock edge):
  - state = FETCH, illegal = 0, instr_count = 0.
  - While reset is low, pc_write, ir_write, mem_write and reg_write are forced to 0. All other outputs keep their FETCH decode.
  - Reset mid-instruction abandons the instruction; it is not counted.
- Internal alu_op encoding: 00 add, 01 sub, 10 use funct decode.
- Funct decode (when alu_op = 10):
  - funct_3 000: sub if op_code[5] & funct_7, else add.
  - 010: slt. 110: or. 111: and.
  - Any other funct_3 on R-type or I-type opcodes is illegal.
- Per-state outputs (unlisted controls are 0; "don't-care" selects are driven to 0):
  - FETCH: adr_src 0, ir_write, src_a 00, src_b 10, add, result_src 10, pc_write. Enables are asserted only when mem_ready = 1; otherwise the FSM stays in FETCH.
  - DECODE: src_a 01, src_b 01, add (branch target goes into alu_out).
  - MEMADR: src_a 10, src_b 01, add.
  - MEMREAD: adr_src 1, result_src 00. The FSM holds until mem_ready.
  - MEMWB: result_src 01, reg_write.
  - MEMWRITE: adr_src 1, result_src 00. mem_write is asserted only in the mem_ready cycle; the FSM holds otherwise.
  - EXECR: src_a 10, src_b 00, alu_op 10.
  - EXECI: src_a 10, src_b 01, alu_op 10.
  - ALUWB: result_src 00, reg_write.
  - BRANCH: src_a 10, src_b 00, sub, result_src 00. pc_write = zero for BEQ, or ~zero for BNE.
  - JAL: src_a 01, src_b 10, add, result_src 00, pc_write.
  - TRAP: all enables 0. Held until reset.
- Transitions:
  - DECODE dispatch by op_code:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXECR
    - 0010011 (I-type) → EXECI
    - 1100011 (branch) → BRANCH
    - 1101111 (jal) → JAL
    - any other opcode → TRAP, with illegal set
  - Bad funct_3 on R-type, I-type or branch opcodes also → TRAP.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB; EXECR and EXECI → ALUWB; JAL → ALUWB.
  - MEMWB, ALUWB, MEMWRITE and BRANCH → FETCH. On each of these exits, instr_count increments by 1 and wraps modulo 2^CNT_W.
- Latency with mem_ready held at 1:
  - lw 5 cycles; sw 4; R-type 4; I-type 4; branch 3; jal 4.
  - Each cycle with mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- With MEM_WAIT_EN = 0, the memory-wait states never stall.
- Outputs are Moore (decoded from state), except:
  - the mem_ready-gated enables in FETCH and MEMWRITE;
  - pc_write in BRANCH, which depends on zero;
  - imm_src, which is decoded directly from op_code.

Test Plan:
- Reset low for 2 cycles, then mem_ready = 1, add x3,x1,x2 (op 0110011, f3 000, f7 0) → states 0,1,6,8,0. alu_control 000 in EXECR, reg_write only in ALUWB, instr_count = 1.
- sub (f7 = 1), then addi with instr[30] = 1 → alu_control 001 for sub; 000 for addi. Both take 4 cycles.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD → total 10 cycles. ir_write pulses exactly once. reg_write with result_src 01 in MEMWB.
- sw → mem_write high for exactly 1 cycle, in the MEMWRITE cycle where mem_ready = 1. imm_src 01. 4 cycles.
- beq with zero = 1 → pc_write = 1 in BRANCH. bne with zero = 1 → pc_write = 0. BNE_EN = 0 with funct_3 001 → TRAP, illegal = 1.
- Opcode 1111111 → TRAP, illegal = 1, all enables 0 for 20 cycles. Reset low → FETCH, illegal = 0. Counter preloaded to all ones, one retire → 0.
